// File: rtl/cc_display_pkg.sv
// Shared constants and state encoding for the 2-digit display scan controller.
package cc_display_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BLANK0 = 3'd1;
  localparam logic [2:0] S_SHOW0  = 3'd2;
  localparam logic [2:0] S_BLANK1 = 3'd3;
  localparam logic [2:0] S_SHOW1  = 3'd4;

  localparam logic [1:0] SEL_DIGIT0 = 2'b00;
  localparam logic [1:0] SEL_DIGIT1 = 2'b01;
  localparam logic [1:0] SEL_OFF    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_BLANK0 = S_BLANK0,
    ST_SHOW0  = S_SHOW0,
    ST_BLANK1 = S_BLANK1,
    ST_SHOW1  = S_SHOW1
  } state_e;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cc_display_scan_timer.sv
// Up-counter with synchronous clear that stops and flags done at the
// selected terminal value.
module cc_display_scan_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  assign o_done = (r_cnt == i_term);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cc_display_scan_controller.sv
// Scans a double-buffered 2-nibble value onto a 2-digit 7-segment display
// with blanking gaps between digits and optional leading-zero suppression.
module cc_display_scan_controller
  import cc_display_pkg::*;
#(
  parameter int unsigned DATAWIDTH_SELECTION = 2,
  parameter int unsigned DATAWIDTH_VALUE     = 8,
  parameter int unsigned DWELL_CYCLES        = 50000,
  parameter int unsigned BLANK_CYCLES        = 500,
  parameter int unsigned LZ_BLANK            = 1
) (
  input  logic                           CC_DISPLAY_SCAN_CLOCK_50,
  input  logic                           CC_DISPLAY_SCAN_RESET_InLow,
  input  logic                           CC_DISPLAY_SCAN_enable_InLow,
  input  logic                           CC_DISPLAY_SCAN_load_In,
  input  logic [DATAWIDTH_VALUE-1:0]     CC_DISPLAY_SCAN_value_InBUS,
  output logic [DATAWIDTH_SELECTION-1:0] CC_DISPLAY_SCAN_selection_OutBUS,
  output logic [NIBBLE_W-1:0]            CC_DISPLAY_SCAN_digit_OutBUS,
  output logic                           CC_DISPLAY_SCAN_frameDone_Out
);

  localparam int unsigned MAXC  = max_u(DWELL_CYCLES, BLANK_CYCLES);
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] DWELL_T = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_T = CNT_W'(BLANK_CYCLES - 1);

  generate
    if (DATAWIDTH_VALUE != 2 * NIBBLE_W) begin : g_bad_value_w
      $error("DATAWIDTH_VALUE must be 8");
    end
    if (DATAWIDTH_SELECTION != 2) begin : g_bad_sel_w
      $error("DATAWIDTH_SELECTION must be 2");
    end
    if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_cycles
      $error("DWELL_CYCLES and BLANK_CYCLES must be >= 1");
    end
  endgenerate

  logic w_clk;
  logic w_rst_n;
  logic w_en;

  assign w_clk   = CC_DISPLAY_SCAN_CLOCK_50;
  assign w_rst_n = CC_DISPLAY_SCAN_RESET_InLow;
  assign w_en    = ~CC_DISPLAY_SCAN_enable_InLow;

  state_e                     r_state;
  state_e                     w_state_nx;
  logic [1:0]                 r_sel;
  logic [1:0]                 w_sel_nx;
  logic [NIBBLE_W-1:0]        r_digit;
  logic [NIBBLE_W-1:0]        w_digit_nx;
  logic                       r_frame;
  logic [DATAWIDTH_VALUE-1:0] r_pending;
  logic                       r_pend_v;
  logic [DATAWIDTH_VALUE-1:0] r_shadow;
  logic [NIBBLE_W-1:0]        w_lo;
  logic [NIBBLE_W-1:0]        w_hi;
  logic [CNT_W-1:0]           w_term;
  logic                       w_tmr_done;
  logic                       w_tmr_clr;
  logic                       w_frame_end;
  logic                       w_show;

  assign w_lo = r_shadow[NIBBLE_W-1:0];
  assign w_hi = r_shadow[2*NIBBLE_W-1:NIBBLE_W];

  assign w_show      = (r_state == ST_SHOW0) || (r_state == ST_SHOW1);
  assign w_term      = w_show ? DWELL_T : BLANK_T;
  assign w_tmr_clr   = (w_state_nx != r_state);
  assign w_frame_end = (r_state == ST_SHOW1) && w_tmr_done && w_en;

  cc_display_scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (w_clk),
    .i_rst_n (w_rst_n),
    .i_clr   (w_tmr_clr),
    .i_term  (w_term),
    .o_done  (w_tmr_done)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_en)       w_state_nx = ST_BLANK0;
      ST_BLANK0: if (w_tmr_done) w_state_nx = ST_SHOW0;
      ST_SHOW0:  if (w_tmr_done) w_state_nx = ST_BLANK1;
      ST_BLANK1: if (w_tmr_done) w_state_nx = ST_SHOW1;
      ST_SHOW1:  if (w_tmr_done) w_state_nx = ST_BLANK0;
      default:                   w_state_nx = ST_IDLE;
    endcase
    if (!w_en) w_state_nx = ST_IDLE;
  end

  // Outputs are computed from the next state so they are registered
  // on the same edge that enters the state.
  always_comb begin
    w_sel_nx   = SEL_OFF;
    w_digit_nx = r_digit;
    unique case (1'b1)
      (w_state_nx == ST_SHOW0): begin
        w_sel_nx   = SEL_DIGIT0;
        w_digit_nx = w_lo;
      end
      (w_state_nx == ST_SHOW1): begin
        w_sel_nx   = (LZ_BLANK != 0 && w_hi == '0) ? SEL_OFF : SEL_DIGIT1;
        w_digit_nx = w_hi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_OFF;
      r_digit <= '0;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_digit <= w_digit_nx;
      r_frame <= w_frame_end;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pending <= '0;
      r_pend_v  <= 1'b0;
      r_shadow  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (CC_DISPLAY_SCAN_load_In) begin
        r_shadow <= CC_DISPLAY_SCAN_value_InBUS;
        r_pend_v <= 1'b0;
      end
    end else if (w_frame_end) begin
      r_pend_v <= 1'b0;
      if (CC_DISPLAY_SCAN_load_In) begin
        r_shadow <= CC_DISPLAY_SCAN_value_InBUS;
      end else if (r_pend_v) begin
        r_shadow <= r_pending;
      end
    end else if (CC_DISPLAY_SCAN_load_In) begin
      r_pending <= CC_DISPLAY_SCAN_value_InBUS;
      r_pend_v  <= 1'b1;
    end
  end

  assign CC_DISPLAY_SCAN_selection_OutBUS = r_sel;
  assign CC_DISPLAY_SCAN_digit_OutBUS     = r_digit;
  assign CC_DISPLAY_SCAN_frameDone_Out    = r_frame;

endmodule

// File: tb/tb_cc_display_scan_controller.sv
// Directed table-driven bench for the display scan controller
// (DWELL=4, BLANK=2, leading-zero blanking on).
module tb_cc_display_scan_controller;

  typedef struct {
    logic       ld;
    logic [7:0] val;
    logic       en_n;
    logic [1:0] sel;
    logic [3:0] dig;
    logic       fd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_n = 1'b1;
  logic       ld = 1'b0;
  logic [7:0] val = 8'h00;
  logic [1:0] sel;
  logic [3:0] dig;
  logic       fd;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  cc_display_scan_controller #(
    .DATAWIDTH_SELECTION (2),
    .DATAWIDTH_VALUE     (8),
    .DWELL_CYCLES        (4),
    .BLANK_CYCLES        (2),
    .LZ_BLANK            (1)
  ) dut (
    .CC_DISPLAY_SCAN_CLOCK_50         (clk),
    .CC_DISPLAY_SCAN_RESET_InLow      (rst_n),
    .CC_DISPLAY_SCAN_enable_InLow     (en_n),
    .CC_DISPLAY_SCAN_load_In          (ld),
    .CC_DISPLAY_SCAN_value_InBUS      (val),
    .CC_DISPLAY_SCAN_selection_OutBUS (sel),
    .CC_DISPLAY_SCAN_digit_OutBUS     (dig),
    .CC_DISPLAY_SCAN_frameDone_Out    (fd)
  );

  task automatic add(input int n, input logic l, input logic [7:0] v,
                     input logic [1:0] s, input logic [3:0] d,
                     input logic f);
    vec_t e;
    e.ld = l; e.val = v; e.en_n = 1'b0;
    e.sel = s; e.dig = d; e.fd = f;
    for (int i = 0; i < n; i++) vq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [1:0] es,
                     input logic [3:0] ed, input logic ef);
    n_tests++;
    if (sel !== es || dig !== ed || fd !== ef) begin
      n_fail++;
      $display("FAIL %s: got sel=%b dig=%h fd=%b, want sel=%b dig=%h fd=%b",
               name, sel, dig, fd, es, ed, ef);
    end
  endtask

  initial begin
    // Startup, value 35, then a 71/72 double load mid SHOW0,
    // then 09 for leading-zero blanking.
    add(1, 1, 8'h35, 2'b11, 4'h0, 0);
    add(2, 0, 8'h00, 2'b11, 4'h0, 0);
    add(4, 0, 8'h00, 2'b00, 4'h5, 0);
    add(2, 0, 8'h00, 2'b11, 4'h5, 0);
    add(4, 0, 8'h00, 2'b01, 4'h3, 0);
    add(1, 0, 8'h00, 2'b11, 4'h3, 1);
    add(1, 0, 8'h00, 2'b11, 4'h3, 0);
    add(1, 0, 8'h00, 2'b00, 4'h5, 0);
    add(1, 1, 8'h71, 2'b00, 4'h5, 0);
    add(1, 1, 8'h72, 2'b00, 4'h5, 0);
    add(1, 0, 8'h00, 2'b00, 4'h5, 0);
    add(2, 0, 8'h00, 2'b11, 4'h5, 0);
    add(4, 0, 8'h00, 2'b01, 4'h3, 0);
    add(1, 0, 8'h00, 2'b11, 4'h3, 1);
    add(1, 0, 8'h00, 2'b11, 4'h3, 0);
    add(3, 0, 8'h00, 2'b00, 4'h2, 0);
    add(1, 1, 8'h09, 2'b00, 4'h2, 0);
    add(2, 0, 8'h00, 2'b11, 4'h2, 0);
    add(4, 0, 8'h00, 2'b01, 4'h7, 0);
    add(1, 0, 8'h00, 2'b11, 4'h7, 1);
    add(1, 0, 8'h00, 2'b11, 4'h7, 0);
    add(4, 0, 8'h00, 2'b00, 4'h9, 0);
    add(2, 0, 8'h00, 2'b11, 4'h9, 0);
    add(4, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 0, 8'h00, 2'b11, 4'h0, 1);
    add(1, 0, 8'h00, 2'b11, 4'h0, 0);
    add(4, 0, 8'h00, 2'b00, 4'h9, 0);
    vq[0].en_n = 1'b1;

    #12;
    chk("reset", 2'b11, 4'h0, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      ld   = vq[i].ld;
      val  = vq[i].val;
      en_n = vq[i].en_n;
      step();
      chk($sformatf("vec%0d", i), vq[i].sel, vq[i].dig, vq[i].fd);
    end
    ld = 1'b0;

    // Enable drop in SHOW1 cycle 2
    step(); chk("drop_blank1", 2'b11, 4'h9, 0);
    run(2);
    step(); chk("drop_show1c2", 2'b11, 4'h0, 0);
    en_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("drop_idle", 2'b11, 4'h0, 0);
    end

    // Direct load in IDLE, then re-enable
    ld = 1'b1; val = 8'h46;
    step(); chk("idle_load", 2'b11, 4'h0, 0);
    ld = 1'b0; en_n = 1'b0;
    step(); chk("reen_blank0", 2'b11, 4'h0, 0);
    run(1);
    step(); chk("reen_show0", 2'b00, 4'h6, 0);
    run(5);
    step(); chk("reen_show1", 2'b01, 4'h4, 0);
    run(3);
    step(); chk("reen_frame", 2'b11, 4'h4, 1);
    run(1);
    step(); chk("pre_reset", 2'b00, 4'h6, 0);

    // Asynchronous reset between edges during SHOW0
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 2'b11, 4'h0, 0);
    #1 rst_n = 1'b1;

    step(); chk("rst_blank0", 2'b11, 4'h0, 0);
    run(1);
    step(); chk("rst_shadow0", 2'b00, 4'h0, 0);
    ld = 1'b1; val = 8'h27;
    step();
    ld = 1'b0;
    run(8);
    ld = 1'b1; val = 8'h81;
    step(); chk("bnd_load_fd", 2'b11, 4'h0, 1);
    ld = 1'b0;
    run(1);
    step(); chk("bnd_show0", 2'b00, 4'h1, 0);
    run(5);
    step(); chk("bnd_show1", 2'b01, 4'h8, 0);
    run(3);
    step(); chk("bnd_frame2", 2'b11, 4'h8, 1);
    run(1);
    step(); chk("bnd_no_stale", 2'b00, 4'h1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
